// File: rtl/led_display_arbiter_pkg.sv
// Shared definitions for the LED display arbiter: segment codes, state encoding,
// requester indices.
package led_display_arbiter_pkg;

   // Active-low segments, bit 7 = a ... bit 1 = g, bit 0 = dp.
   localparam logic [7:0] NONE      = 8'b1111_1111;
   localparam logic [7:0] ZERO      = 8'b0000_0011;
   localparam logic [7:0] ONE       = 8'b1001_1111;
   localparam logic [7:0] TWO       = 8'b0010_0101;
   localparam logic [7:0] THREE     = 8'b0000_1101;
   localparam logic [7:0] FOUR      = 8'b1001_1001;
   localparam logic [7:0] CORRECT   = 8'b0110_0011;
   localparam logic [7:0] INCORRECT = 8'b0110_0001;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShow  = 2'd1,
      StBlank = 2'd2
   } arb_state_e;

   localparam logic [1:0] ReqLock  = 2'd0;
   localparam logic [1:0] ReqAlarm = 2'd1;
   localparam logic [1:0] ReqCount = 2'd2;

   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over three requesters; the search starts
// just after the previous winner.
module rr_pick3 (
   input  logic [2:0] req_i,
   input  logic [1:0] last_i,
   output logic [1:0] winner_o,
   output logic       valid_o
);

   logic [1:0] idx;
   logic       found;

   always_comb begin
      winner_o = 2'd0;
      found    = 1'b0;
      idx      = (last_i >= 2'd2) ? 2'd0 : last_i + 2'd1;
      for (int k = 0; k < 3; k++) begin
         if (!found && req_i[idx]) begin
            winner_o = idx;
            found    = 1'b1;
         end
         idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
      valid_o = found;
   end

endmodule

// File: rtl/led_display_arbiter.sv
// Shares one 7-segment LED between three requesters: round-robin ownership with a
// minimum hold under contention and a blank gap between owners.
module led_display_arbiter
   import led_display_arbiter_pkg::*;
#(
   parameter logic [12:0] HOLD_TICKS    = 13'd7199,
   parameter logic [7:0]  BLANK_TICKS   = 8'd255,
   parameter logic [7:0]  BLANK_PATTERN = NONE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic [2:0]  req,
   input  logic [23:0] req_pattern,
   output logic [2:0]  grant,
   output logic [7:0]  LED,
   output logic        busy
);

   localparam logic [12:0] HoldEff   = (HOLD_TICKS == 13'd0) ? 13'd1 : HOLD_TICKS;
   localparam logic [12:0] HoldLast  = HoldEff - 13'd1;
   localparam logic [7:0]  BlankLast = BLANK_TICKS - 8'd1;

   arb_state_e  state_q, state_d;
   logic [2:0]  grant_q, grant_d;
   logic [7:0]  led_q, led_d;
   logic [12:0] hold_cnt_q, hold_cnt_d;
   logic [7:0]  blank_cnt_q, blank_cnt_d;
   logic [1:0]  last_q, last_d;

   logic [1:0]  pick_idx;
   logic        pick_valid;
   logic [12:0] hold_inc;
   logic [7:0]  owner_pat;
   logic        owner_req, other_req, release_now, arb;

   rr_pick3 u_pick (
      .req_i    (req),
      .last_i   (last_q),
      .winner_o (pick_idx),
      .valid_o  (pick_valid)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      led_d       = led_q;
      hold_cnt_d  = hold_cnt_q;
      blank_cnt_d = blank_cnt_q;
      last_d      = last_q;
      arb         = 1'b0;

      hold_inc    = (hold_cnt_q >= HoldEff) ? hold_cnt_q : hold_cnt_q + 13'd1;
      owner_req   = |(req & grant_q);
      other_req   = |(req & ~grant_q);
      release_now = tick && (!owner_req || (other_req && hold_inc >= HoldLast));

      unique case (last_q)
         ReqLock:  owner_pat = req_pattern[7:0];
         ReqAlarm: owner_pat = req_pattern[15:8];
         default:  owner_pat = req_pattern[23:16];
      endcase

      unique case (state_q)
         StIdle: begin
            led_d = BLANK_PATTERN;
            arb   = tick;
         end
         StShow: begin
            led_d = owner_pat;
            if (tick) hold_cnt_d = hold_inc;
            if (release_now) begin
               grant_d     = 3'b000;
               led_d       = BLANK_PATTERN;
               blank_cnt_d = 8'd0;
               if (BLANK_TICKS == 8'd0) arb = 1'b1;
               else state_d = StBlank;
            end
         end
         StBlank: begin
            led_d   = BLANK_PATTERN;
            grant_d = 3'b000;
            if (tick) begin
               if (blank_cnt_q == BlankLast) arb = 1'b1;
               else blank_cnt_d = blank_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = 3'b000;
            led_d   = BLANK_PATTERN;
         end
      endcase

      // Shared arbitration step for IDLE, end of BLANK and zero-length blank.
      if (arb) begin
         if (pick_valid) begin
            state_d    = StShow;
            grant_d    = onehot3(pick_idx);
            last_d     = pick_idx;
            hold_cnt_d = 13'd0;
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         grant_q     <= 3'b000;
         led_q       <= BLANK_PATTERN;
         hold_cnt_q  <= 13'd0;
         blank_cnt_q <= 8'd0;
         last_q      <= ReqCount;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         led_q       <= led_d;
         hold_cnt_q  <= hold_cnt_d;
         blank_cnt_q <= blank_cnt_d;
         last_q      <= last_d;
      end
   end

   assign grant = grant_q;
   assign LED   = led_q;
   assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed bench for led_display_arbiter with HOLD_TICKS = 4, BLANK_TICKS = 2.
module tb_led_display_arbiter;

   logic        clk;
   logic        reset;
   logic        tick;
   logic [2:0]  req;
   logic [23:0] req_pattern;
   logic [2:0]  grant;
   logic [7:0]  led;
   logic        busy;

   int checks;
   int failures;

   led_display_arbiter #(
      .HOLD_TICKS    (13'd4),
      .BLANK_TICKS   (8'd2),
      .BLANK_PATTERN (8'hFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .req         (req),
      .req_pattern (req_pattern),
      .grant       (grant),
      .LED         (led),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock with the given tick level; returns 1 time unit after the edge.
   task automatic clk_cycle(input logic t);
      tick = t;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic reset_dut();
      req   = 3'b000;
      reset = 1'b1;
      clk_cycle(1'b0);
      reset = 1'b0;
      clk_cycle(1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if (grant !== 3'b000) begin
         failures++; $display("FAIL reset_grant: got %b expected 000", grant);
      end
      checks++;
      if (led !== 8'hFF) begin
         failures++; $display("FAIL reset_led: got %h expected ff", led);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      clk_cycle(1'b0);
      reset = 1'b0;
      clk_cycle(1'b0);
   endtask

   task automatic test_single();
      int held;
      reset_dut();
      req_pattern = {8'hFF, 8'hFF, 8'h03};
      req = 3'b001;
      clk_cycle(1'b1);
      checks++;
      if (grant !== 3'b001) begin
         failures++; $display("FAIL single_grant: got %b expected 001", grant);
      end
      clk_cycle(1'b0);
      checks++;
      if (led !== 8'h03) begin
         failures++; $display("FAIL single_led: got %h expected 03", led);
      end
      held = 0;
      for (int i = 0; i < 20; i++) begin
         clk_cycle(1'b1);
         if (grant === 3'b001 && led === 8'h03 && busy === 1'b1) held++;
      end
      checks++;
      if (held !== 20) begin
         failures++; $display("FAIL single_hold20: got %0d held ticks expected 20", held);
      end
   endtask

   task automatic test_contention();
      reset_dut();
      req_pattern = {8'h25, 8'h9F, 8'h03};
      req = 3'b001;
      clk_cycle(1'b1);            // grant 0, hold 0
      req = 3'b011;
      clk_cycle(1'b1);            // hold 1
      clk_cycle(1'b1);            // hold 2
      checks++;
      if (grant !== 3'b001) begin
         failures++; $display("FAIL cont_before_release: got %b expected 001", grant);
      end
      clk_cycle(1'b1);            // hold reaches 3 -> release
      checks++;
      if (grant !== 3'b000 || led !== 8'hFF || busy !== 1'b1) begin
         failures++;
         $display("FAIL cont_release: got g=%b led=%h busy=%b expected g=000 led=ff busy=1",
                  grant, led, busy);
      end
      clk_cycle(1'b1);            // blank tick 1
      checks++;
      if (grant !== 3'b000 || led !== 8'hFF) begin
         failures++; $display("FAIL cont_blank1: got g=%b led=%h expected g=000 led=ff",
                              grant, led);
      end
      clk_cycle(1'b1);            // blank tick 2 -> arbitrate
      checks++;
      if (grant !== 3'b010) begin
         failures++; $display("FAIL cont_grant1: got %b expected 010", grant);
      end
      clk_cycle(1'b0);
      checks++;
      if (led !== 8'h9F) begin
         failures++; $display("FAIL cont_led1: got %h expected 9f", led);
      end
   endtask

   task automatic test_fairness();
      logic [7:0] pats [3];
      logic [2:0] prev;
      logic [2:0] exp_g;
      logic [7:0] exp_l;
      int         jumps;
      int         phase;
      int         owner;
      pats[0] = 8'h03; pats[1] = 8'h9F; pats[2] = 8'h25;
      reset_dut();
      req_pattern = {pats[2], pats[1], pats[0]};
      req = 3'b111;
      prev  = 3'b000;
      jumps = 0;
      for (int k = 1; k <= 30; k++) begin
         clk_cycle(1'b1);
         // 3 ticks shown (release on the 4th incl. increment), then 2 blank ticks
         phase = (k - 1) % 5;
         owner = ((k - 1) / 5) % 3;
         exp_g = (phase < 3) ? (3'b001 << owner) : 3'b000;
         exp_l = (phase == 1 || phase == 2) ? pats[owner] : 8'hFF;
         checks++;
         if (grant !== exp_g || led !== exp_l) begin
            failures++;
            $display("FAIL rr_tick%0d: got g=%b led=%h expected g=%b led=%h",
                     k, grant, led, exp_g, exp_l);
         end
         if (prev !== 3'b000 && grant !== 3'b000 && grant !== prev) jumps++;
         prev = grant;
      end
      checks++;
      if (jumps !== 0) begin
         failures++; $display("FAIL rr_no_direct_handoff: got %0d jumps expected 0", jumps);
      end
   endtask

   task automatic test_owner_drop();
      reset_dut();
      req_pattern = {8'h25, 8'h9F, 8'h03};
      req = 3'b100;
      clk_cycle(1'b1);            // owner 2, hold 0
      checks++;
      if (grant !== 3'b100) begin
         failures++; $display("FAIL drop_grant: got %b expected 100", grant);
      end
      clk_cycle(1'b1);            // hold 1
      req = 3'b000;
      clk_cycle(1'b1);            // release via owner drop
      checks++;
      if (grant !== 3'b000 || led !== 8'hFF || busy !== 1'b1) begin
         failures++;
         $display("FAIL drop_release: got g=%b led=%h busy=%b expected g=000 led=ff busy=1",
                  grant, led, busy);
      end
      clk_cycle(1'b1);
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL drop_blank_busy: got %b expected 1", busy);
      end
      clk_cycle(1'b1);            // blank ends, nothing pending
      checks++;
      if (grant !== 3'b000 || led !== 8'hFF || busy !== 1'b0) begin
         failures++;
         $display("FAIL drop_idle: got g=%b led=%h busy=%b expected g=000 led=ff busy=0",
                  grant, led, busy);
      end
   endtask

   task automatic test_live_pattern();
      int steady;
      reset_dut();
      req_pattern = {8'hFF, 8'hFF, 8'h9F};
      req = 3'b001;
      clk_cycle(1'b1);
      clk_cycle(1'b0);
      checks++;
      if (led !== 8'h9F) begin
         failures++; $display("FAIL live_led_a: got %h expected 9f", led);
      end
      req_pattern = {8'hFF, 8'hFF, 8'h25};
      #1;
      checks++;
      if (led !== 8'h9F) begin
         failures++; $display("FAIL live_led_registered: got %h expected 9f", led);
      end
      clk_cycle(1'b0);
      checks++;
      if (led !== 8'h25) begin
         failures++; $display("FAIL live_led_b: got %h expected 25", led);
      end
      // Owner drops without any tick: nothing may change.
      req = 3'b010;
      steady = 0;
      for (int i = 0; i < 5; i++) begin
         clk_cycle(1'b0);
         if (grant === 3'b001 && busy === 1'b1 && led === 8'h25) steady++;
      end
      checks++;
      if (steady !== 5) begin
         failures++; $display("FAIL live_no_tick: got %0d steady clks expected 5", steady);
      end
   endtask

   task automatic test_reset_mid_show();
      reset_dut();
      req_pattern = {8'h25, 8'h9F, 8'h03};
      req = 3'b111;
      clk_cycle(1'b1);
      clk_cycle(1'b0);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (grant !== 3'b000 || led !== 8'hFF || busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: got g=%b led=%h busy=%b expected g=000 led=ff busy=0",
                  grant, led, busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      clk_cycle(1'b1);
      checks++;
      if (grant !== 3'b001) begin
         failures++; $display("FAIL mid_reset_regrant: got %b expected 001", grant);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      tick        = 1'b0;
      req         = 3'b000;
      req_pattern = 24'hFFFFFF;
      reset       = 1'b1;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_owner_drop();
      test_live_pattern();
      test_reset_mid_show();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
